mask_index_streamer: RTL and testbench

- Accepts an N-bit bit mask via a rdy/ack handshake.
- Emits the index of every set bit, one per cycle, LSB first, via a second rdy/ack handshake.
- Uses find-first-from-LSB to locate the lowest remaining set bit and clears it after each accepted index.
- Sits downstream of mask producers (bank/lane enable vectors) and feeds per-index issue logic.

---
 rtl/mask_index_streamer_pkg.sv | 31 +++
 rtl/mask_index_streamer_if.sv | 29 ++
 rtl/mask_index_streamer_lsb_onehot_find.sv | 21 ++
 rtl/mask_index_streamer.sv | 79 +++++++
 tb/tb_mask_index_streamer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mask_index_streamer_pkg.sv
// Shared types and helpers for the mask index streamer.
//   idx_t         : index type for the default mask width
//   state_t       : scanner FSM state
//   onehot_to_bin : one-hot to binary encoder, also usable by arbiters.
//                   Handles one-hot vectors up to OH_MAX bits wide.
package mask_index_streamer_pkg;

    localparam int N_DEF  = 10;
    localparam int LG_DEF = $clog2(N_DEF);
    localparam int OH_MAX = 64;
    localparam int OH_LG  = 6;

    typedef logic [LG_DEF-1:0] idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // OR of the positions of all set bits.
    // For a one-hot input this is exactly its index.
    // An all-zero input encodes to 0.
    function automatic logic [OH_LG-1:0] onehot_to_bin(input logic [OH_MAX-1:0] oh);
        logic [OH_LG-1:0] b;
        b = '0;
        for (int i = 0; i < OH_MAX; i++)
            if (oh[i]) b = b | OH_LG'(i);
        return b;
    endfunction

endpackage

// File: rtl/mask_index_streamer_if.sv
// Handshake bundle for mask_index_streamer.
//   i_mask / i_mask_rdy / o_mask_ack              : mask input channel
//   o_idx / o_first / o_last / o_idx_rdy / i_idx_ack : index output channel
// The slave modport is the streamer itself.
// The master modport is the side that produces masks and consumes indices.
interface mask_index_streamer_if #(
    parameter int N = 10
);
    import mask_index_streamer_pkg::*;

    logic [N-1:0]         i_mask;
    logic                 i_mask_rdy;
    logic                 o_mask_ack;
    logic [$clog2(N)-1:0] o_idx;
    logic                 o_first;
    logic                 o_last;
    logic                 o_idx_rdy;
    logic                 i_idx_ack;

    modport slave (
        input  i_mask, i_mask_rdy, i_idx_ack,
        output o_mask_ack, o_idx, o_first, o_last, o_idx_rdy
    );

    modport master (
        output i_mask, i_mask_rdy, i_idx_ack,
        input  o_mask_ack, o_idx, o_first, o_last, o_idx_rdy
    );
endinterface

// File: rtl/mask_index_streamer_lsb_onehot_find.sv
// Find-first-set from the LSB.
//   rem : vector to scan
//   low : one-hot of the lowest set bit of rem; all zero when rem == 0
// seen[i] is the prefix OR of rem[i-1:0].
// A bit survives into low only if no lower bit is set.
module lsb_onehot_find #(
    parameter int N = 10
) (
    input  logic [N-1:0] rem,
    output logic [N-1:0] low
);
    logic [N-1:0] seen;

    always_comb begin
        seen = '0;
        for (int i = 1; i < N; i++)
            seen[i] = seen[i-1] | rem[i-1];
    end

    assign low = rem & ~seen;
endmodule

// File: rtl/mask_index_streamer.sv
// Streams the index of every set bit of an accepted mask, lowest bit first,
// one index per accepted output transfer.
//   i_clk, i_rst   : clock and asynchronous active-low reset
//   bus (slave)    : mask in  (i_mask, i_mask_rdy, o_mask_ack)
//                    index out (o_idx, o_first, o_last, o_idx_rdy, i_idx_ack)
// The index outputs are decoded from registers only.
// The single combinational input-to-output path is i_idx_ack -> o_mask_ack.
// That path lets a new mask load on the same cycle the last index leaves.
// N must not exceed the encoder width in the package (64).
module mask_index_streamer
    import mask_index_streamer_pkg::*;
#(
    parameter int N = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mask_index_streamer_if.slave  bus
);
    localparam int LG = $clog2(N);

    state_t       state;
    logic [N-1:0] rem;
    logic [N-1:0] low;
    logic         first_r;
    logic         idx_rdy;
    logic         last;
    logic         mask_ack;
    logic         mask_xfer;
    logic         idx_xfer;

    lsb_onehot_find #(.N(N)) u_find (
        .rem (rem),
        .low (low)
    );

    assign idx_rdy = (state == BUSY);

    // Qualified with BUSY so that an idle block (rem == 0) does not show last.
    assign last = idx_rdy && ((rem & ~low) == '0);

    assign mask_ack  = (state == IDLE) | (idx_rdy & bus.i_idx_ack & last);
    assign mask_xfer = bus.i_mask_rdy & mask_ack;
    assign idx_xfer  = idx_rdy & bus.i_idx_ack;

    assign bus.o_idx_rdy  = idx_rdy;
    assign bus.o_first    = first_r;
    assign bus.o_last     = last;
    assign bus.o_mask_ack = mask_ack;
    assign bus.o_idx      = LG'(onehot_to_bin(OH_MAX'(low)));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            rem     <= '0;
            first_r <= 1'b0;
        end else if (mask_xfer) begin
            // In BUSY this only happens on the last index,
            // so loading the new mask takes priority over retiring the old one.
            // A zero mask is swallowed without producing an index.
            if (bus.i_mask != '0) begin
                rem     <= bus.i_mask;
                first_r <= 1'b1;
                state   <= BUSY;
            end else begin
                rem     <= '0;
                first_r <= 1'b0;
                state   <= IDLE;
            end
        end else if (idx_xfer) begin
            first_r <= 1'b0;
            if (last) begin
                rem   <= '0;
                state <= IDLE;
            end else begin
                rem   <= rem & ~low;
            end
        end
    end
endmodule

// File: tb/tb_mask_index_streamer.sv
module tb_mask_index_streamer;
    import mask_index_streamer_pkg::*;

    localparam int N = 10;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    mask_index_streamer_if #(.N(N)) bus();

    mask_index_streamer #(.N(N)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One record per cycle: inputs driven on the negedge,
    // outputs compared 1ns later.
    typedef struct {
        logic         rdy;
        logic [N-1:0] mask;
        logic         ack;
        logic         e_rdy;
        idx_t         e_idx;
        logic         e_first;
        logic         e_last;
        logic         e_mack;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic rdy, input logic [N-1:0] mask, input logic ack,
                       input logic e_rdy, input int e_idx,
                       input logic e_first, input logic e_last, input logic e_mack);
        vec_t v;
        v.rdy = rdy; v.mask = mask; v.ack = ack;
        v.e_rdy = e_rdy; v.e_idx = idx_t'(e_idx);
        v.e_first = e_first; v.e_last = e_last; v.e_mack = e_mack;
        vecs.push_back(v);
    endtask

    typedef struct {
        idx_t idx;
        logic first;
        logic last;
    } exp_t;
    exp_t sb[$];

    initial begin
        int sent;
        int cycles;
        logic pend;
        logic [N-1:0] pm;

        bus.i_mask     = '0;
        bus.i_mask_rdy = 1'b0;
        bus.i_idx_ack  = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge i_clk);
        #1;
        chk("reset o_idx_rdy", bus.o_idx_rdy, 0);
        chk("reset o_idx",     bus.o_idx,     0);
        chk("reset o_first",   bus.o_first,   0);
        chk("reset o_last",    bus.o_last,    0);
        i_rst = 1'b1;
        #1;
        chk("post-reset o_mask_ack", bus.o_mask_ack, 1);

        // ---- directed table ----
        // basic scan of 10'b10_0010_0101: 0,2,5,9
        add(1, 10'h225, 1, 0, 0, 0, 0, 1);
        add(0, 10'h000, 1, 1, 0, 1, 0, 0);
        add(0, 10'h000, 1, 1, 2, 0, 0, 0);
        add(0, 10'h000, 1, 1, 5, 0, 0, 0);
        add(0, 10'h000, 1, 1, 9, 0, 1, 1);
        add(0, 10'h000, 1, 0, 0, 0, 0, 1);
        // back-to-back single-bit masks, no bubble
        add(1, 10'h001, 1, 0, 0, 0, 0, 1);
        add(1, 10'h200, 1, 1, 0, 1, 1, 1);
        add(0, 10'h000, 1, 1, 9, 1, 1, 1);
        add(0, 10'h000, 1, 0, 0, 0, 0, 1);
        // zero mask consumed silently, then 10'b100
        add(1, 10'h000, 1, 0, 0, 0, 0, 1);
        add(1, 10'h004, 1, 0, 0, 0, 0, 1);
        add(0, 10'h000, 1, 1, 2, 1, 1, 1);
        add(0, 10'h000, 1, 0, 0, 0, 0, 1);
        // full mask with a 3-cycle stall on index 1.
        // A competing mask is offered during the stall and must be ignored.
        add(1, 10'h3FF, 1, 0, 0, 0, 0, 1);
        add(0, 10'h000, 1, 1, 0, 1, 0, 0);
        add(1, 10'h0F0, 0, 1, 1, 0, 0, 0);
        add(1, 10'h0F0, 0, 1, 1, 0, 0, 0);
        add(1, 10'h0F0, 0, 1, 1, 0, 0, 0);
        add(1, 10'h0F0, 1, 1, 1, 0, 0, 0);
        for (int i = 2; i < 9; i++) add(0, 10'h000, 1, 1, i, 0, 0, 0);
        add(0, 10'h000, 1, 1, 9, 0, 1, 1);
        add(0, 10'h000, 0, 0, 0, 0, 0, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge i_clk);
            bus.i_mask_rdy = vecs[k].rdy;
            bus.i_mask     = vecs[k].mask;
            bus.i_idx_ack  = vecs[k].ack;
            #1;
            chk($sformatf("row%0d o_idx_rdy", k),  bus.o_idx_rdy,  vecs[k].e_rdy);
            chk($sformatf("row%0d o_idx", k),      bus.o_idx,      vecs[k].e_idx);
            chk($sformatf("row%0d o_first", k),    bus.o_first,    vecs[k].e_first);
            chk($sformatf("row%0d o_last", k),     bus.o_last,     vecs[k].e_last);
            chk($sformatf("row%0d o_mask_ack", k), bus.o_mask_ack, vecs[k].e_mack);
        end

        // ---- async reset mid-scan ----
        @(negedge i_clk);
        bus.i_mask_rdy = 1'b1;
        bus.i_mask     = 10'h3FF;
        bus.i_idx_ack  = 1'b1;
        #1;
        chk("arst load ack", bus.o_mask_ack, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            bus.i_mask_rdy = 1'b0;
            #1;
            chk($sformatf("arst pre idx%0d", k), bus.o_idx, k);
        end
        @(negedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        chk("arst o_idx_rdy immediate", bus.o_idx_rdy, 0);
        chk("arst o_idx immediate",     bus.o_idx,     0);
        chk("arst o_first immediate",   bus.o_first,   0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("arst release o_mask_ack", bus.o_mask_ack, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            #1;
            chk($sformatf("arst no stale %0d", k), bus.o_idx_rdy, 0);
        end

        // ---- random masks against a scoreboard ----
        sent   = 0;
        cycles = 0;
        pend   = 1'b0;
        pm     = '0;
        while ((sent < 1000 || pend || sb.size() != 0 || bus.o_idx_rdy) && cycles < 60000) begin
            @(negedge i_clk);
            cycles++;
            if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                case ($urandom_range(0, 7))
                    0:       pm = '0;
                    1:       pm = '1;
                    default: pm = N'($urandom);
                endcase
            end
            bus.i_mask_rdy = pend;
            bus.i_mask     = pend ? pm : N'($urandom);
            bus.i_idx_ack  = ($urandom_range(0, 3) != 0);
            #1;
            if (sb.size() == 0) begin
                chk("rnd spurious o_idx_rdy", bus.o_idx_rdy, 0);
            end else if (bus.o_idx_rdy && bus.i_idx_ack) begin
                exp_t e;
                e = sb.pop_front();
                chk("rnd o_idx",   bus.o_idx,   e.idx);
                chk("rnd o_first", bus.o_first, e.first);
                chk("rnd o_last",  bus.o_last,  e.last);
            end
            if (pend && bus.o_mask_ack) begin
                logic f;
                f = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (pm[i]) begin
                        exp_t e;
                        e.idx   = idx_t'(i);
                        e.first = f;
                        e.last  = ((pm >> (i + 1)) == '0);
                        f = 1'b0;
                        sb.push_back(e);
                    end
                end
                pend = 1'b0;
                sent++;
            end
        end
        if (cycles >= 60000) begin
            errors++;
            checks++;
            $display("FAIL rnd timeout: sent %0d of 1000, %0d indices outstanding", sent, sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
